// File: rtl/boton_eventos.sv
// Turns a debounced button level into one-clock short/double/long press pulses.
// Define BTN_AUTOREPEAT_EN to build the auto-repeat counter that drives repeat_press.
module boton_eventos #(
  parameter int TICK_1MS  = 50000,
  parameter int LONG_MS   = 1000,
  parameter int DOUBLE_MS = 300,
  parameter int REPEAT_MS = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_press,
  output logic held
);

  localparam int PW        = (TICK_1MS > 1) ? $clog2(TICK_1MS) : 1;
  localparam int MS_MAX_LD = (LONG_MS > DOUBLE_MS) ? LONG_MS : DOUBLE_MS;
  localparam int MS_MAX    = (MS_MAX_LD > REPEAT_MS) ? MS_MAX_LD : REPEAT_MS;
  localparam int MW        = $clog2(MS_MAX + 1);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_1MS - 1);
  localparam logic [MW-1:0] LONG_LAST   = MW'(LONG_MS - 1);
  localparam logic [MW-1:0] DOUBLE_LAST = MW'(DOUBLE_MS - 1);
  localparam logic [MW-1:0] MS_TOP      = MW'(MS_MAX);

  typedef enum logic [2:0] {
    WREL,
    IDLE,
    PRESS,
    LONG,
    GAP,
    PRESS2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [PW-1:0]   r_presc;
  logic [MW-1:0]   r_msCnt;
  logic            w_msTick;
  logic            w_short;
  logic            w_double;
  logic            w_long;
  logic            r_short;
  logic            r_double;
  logic            r_long;
  logic            r_held;

  assign w_msTick = (r_presc == PRESC_LAST);

  // Timers restart on every state change so each window is measured from its own entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= WREL;
      r_presc  <= '0;
      r_msCnt  <= '0;
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_short  <= w_short;
      r_double <= w_double;
      r_long   <= w_long;
      r_held   <= (w_nextState == PRESS) || (w_nextState == LONG) ||
                  (w_nextState == PRESS2);
      if (w_nextState != r_state) begin
        r_presc <= '0;
        r_msCnt <= '0;
      end else begin
        if (w_msTick) begin
          r_presc <= '0;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
        if (w_msTick && (r_msCnt != MS_TOP)) begin
          r_msCnt <= r_msCnt + 1'b1;
        end
      end
    end
  end

  // Level changes are tested before timeouts, so a release or press on the terminal tick wins.
  always_comb begin
    w_nextState = r_state;
    w_short     = 1'b0;
    w_double    = 1'b0;
    w_long      = 1'b0;
    case (r_state)
      WREL: begin
        if (!btn_level) w_nextState = IDLE;
      end
      IDLE: begin
        if (btn_level) w_nextState = PRESS;
      end
      PRESS: begin
        if (!btn_level) begin
          w_nextState = GAP;
        end else if (w_msTick && (r_msCnt == LONG_LAST)) begin
          w_nextState = LONG;
          w_long      = 1'b1;
        end
      end
      LONG: begin
        if (!btn_level) w_nextState = IDLE;
      end
      GAP: begin
        if (btn_level) begin
          w_nextState = PRESS2;
        end else if (w_msTick && (r_msCnt == DOUBLE_LAST)) begin
          w_nextState = IDLE;
          w_short     = 1'b1;
        end
      end
      PRESS2: begin
        if (!btn_level) begin
          w_nextState = IDLE;
          w_double    = 1'b1;
        end
      end
      default: begin
        w_nextState = WREL;
      end
    endcase
  end

  assign short_press  = r_short;
  assign double_press = r_double;
  assign long_press   = r_long;
  assign held         = r_held;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = (REPEAT_MS > 1) ? $clog2(REPEAT_MS) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_MS - 1);

  logic [RW-1:0] r_repCnt;
  logic          r_repeat;

  // Counter is held at zero outside LONG; gating with btn_level drops the pulse on release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_repCnt <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      if (r_state != LONG) begin
        r_repCnt <= '0;
      end else if (w_msTick) begin
        if (r_repCnt == REP_LAST) begin
          r_repCnt <= '0;
          r_repeat <= btn_level;
        end else begin
          r_repCnt <= r_repCnt + 1'b1;
        end
      end
    end
  end

  assign repeat_press = r_repeat;
`else
  assign repeat_press = 1'b0;
`endif

endmodule

// File: tb/tb_boton_eventos.sv
// Scoreboard bench for boton_eventos with TICK_1MS=10, LONG_MS=5, DOUBLE_MS=3, REPEAT_MS=2.
module tb_boton_eventos;

  localparam int TICK   = 10;
  localparam int LONGM  = 5;
  localparam int DBLM   = 3;
  localparam int REPM   = 2;
  localparam int LONG_LAT  = LONGM * TICK + 1;
  localparam int SHORT_LAT = DBLM * TICK + 1;
  localparam int REP_PER   = REPM * TICK;

  typedef enum int {EV_SHORT, EV_DOUBLE, EV_LONG, EV_REPEAT} ev_t;
  typedef struct {
    ev_t kind;
    int  cycle;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic btnLevel;
  logic shortPress;
  logic doublePress;
  logic longPress;
  logic repeatPress;
  logic held;

  int   cyc = 0;
  int   testsRun = 0;
  int   testsFailed = 0;
  exp_t expQ[$];

  boton_eventos #(
    .TICK_1MS (TICK),
    .LONG_MS  (LONGM),
    .DOUBLE_MS(DBLM),
    .REPEAT_MS(REPM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_level   (btnLevel),
    .short_press (shortPress),
    .double_press(doublePress),
    .long_press  (longPress),
    .repeat_press(repeatPress),
    .held        (held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic applyStimulus(input logic level, input int cycles);
    btnLevel = level;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [4:0] actual,
                             input logic [4:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExp(input ev_t kind, input int cycle);
    exp_t e;
    e.kind  = kind;
    e.cycle = cycle;
    expQ.push_back(e);
  endtask

  // Monitor: any event pulse pops the next expectation and checks its type and cycle.
  always @(negedge clk) begin
    logic [3:0] ev;
    ev_t        got;
    exp_t       e;
    ev = {shortPress, doublePress, longPress, repeatPress};
    if (ev != 4'b0000) begin
      if (shortPress)       got = EV_SHORT;
      else if (doublePress) got = EV_DOUBLE;
      else if (longPress)   got = EV_LONG;
      else                  got = EV_REPEAT;
      testsRun++;
      if ($countones(ev) != 1) begin
        testsFailed++;
        $display("[TB] FAIL one_hot_events: got %b at cycle %0d, expected one bit", ev, cyc);
      end else if (expQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpected_event: got %s at cycle %0d, expected none",
                 got.name(), cyc);
      end else begin
        e = expQ.pop_front();
        if (e.kind != got || e.cycle != cyc) begin
          testsFailed++;
          $display("[TB] FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                   got.name(), cyc, e.kind.name(), e.cycle);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int r;
    reset    = 1'b0;
    btnLevel = 1'b0;
    applyStimulus(0, 3);
    checkOutput("reset_outputs", {shortPress, doublePress, longPress, repeatPress, held}, 5'b0);
    reset = 1'b1;
    applyStimulus(0, 3);

    // Short press: 20 cycles held, release sampled at r.
    applyStimulus(1, 5);
    checkOutput("held_in_press", {4'b0, held}, 5'b00001);
    applyStimulus(1, 15);
    r = cyc;
    pushExp(EV_SHORT, r + SHORT_LAT);
    applyStimulus(0, 5);
    checkOutput("held_in_gap", {4'b0, held}, 5'b0);
    applyStimulus(0, 95);

    // Double press.
    applyStimulus(1, 20);
    applyStimulus(0, 10);
    applyStimulus(1, 5);
    checkOutput("held_in_press2", {4'b0, held}, 5'b00001);
    applyStimulus(1, 15);
    r = cyc;
    pushExp(EV_DOUBLE, r + 1);
    applyStimulus(0, 100);

    // Long press held 200 cycles.
    t = cyc;
    pushExp(EV_LONG, t + LONG_LAT);
`ifdef BTN_AUTOREPEAT_EN
    for (int k = 1; t + LONG_LAT + k * REP_PER < t + 200; k++) begin
      pushExp(EV_REPEAT, t + LONG_LAT + k * REP_PER);
    end
`endif
    applyStimulus(1, 100);
    checkOutput("held_in_long", {4'b0, held}, 5'b00001);
    applyStimulus(1, 100);
    applyStimulus(0, 60);

    // Button held through reset release: nothing until released.
    reset = 1'b0;
    applyStimulus(1, 3);
    checkOutput("reset_outputs_btn_held", {shortPress, doublePress, longPress, repeatPress, held}, 5'b0);
    reset = 1'b1;
    applyStimulus(1, 80);
    checkOutput("held_in_wrel", {4'b0, held}, 5'b0);
    applyStimulus(0, 5);
    applyStimulus(1, 20);
    r = cyc;
    pushExp(EV_SHORT, r + SHORT_LAT);
    applyStimulus(0, 50);

    // Release on the long terminal tick: release wins, short follows.
    applyStimulus(1, LONGM * TICK);
    r = cyc;
    pushExp(EV_SHORT, r + SHORT_LAT);
    applyStimulus(0, 50);

    // Second press on the double terminal tick: press wins, double follows.
    applyStimulus(1, 20);
    applyStimulus(0, DBLM * TICK);
    applyStimulus(1, 10);
    r = cyc;
    pushExp(EV_DOUBLE, r + 1);
    applyStimulus(0, 50);

    // Reset pulsed during GAP: pending short is discarded.
    applyStimulus(1, 20);
    applyStimulus(0, 10);
    reset = 1'b0;
    applyStimulus(0, 1);
    checkOutput("reset_in_gap_a", {shortPress, doublePress, longPress, repeatPress, held}, 5'b0);
    applyStimulus(0, 2);
    checkOutput("reset_in_gap_b", {shortPress, doublePress, longPress, repeatPress, held}, 5'b0);
    reset = 1'b1;
    applyStimulus(0, 60);
    applyStimulus(1, 20);
    r = cyc;
    pushExp(EV_SHORT, r + SHORT_LAT);
    applyStimulus(0, 50);

    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL pending_events: got %0d outstanding, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
